if_fetch_unit: RTL and testbench

//   Instruction-fetch producer feeding the IF/ID pipeline register.

---
 rtl/if_fetch_unit_if.sv | 22 ++
 rtl/if_fetch_unit.sv | 111 +++++++++++
 tb/tb_if_fetch_unit.sv | 258 +++++++++++++++++++++++++
 3 files changed

// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read channel between if_fetch_unit (master) and the
// instruction memory (slave): one request/address, one ready/data return.
interface if_fetch_unit_if;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        imem_ready;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_data,
    input  imem_ready
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_data,
    output imem_ready
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction-fetch producer for the IF/ID register: PA-RISC front/back PC queue,
// imem request handshake and delayed-branch redirect. Option macro: IF_NULLIFY_EN.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INST = 32'h0800_0240
) (
  input  logic                   clk,
  input  logic                   Reset,
  input  logic                   LE,
  input  logic                   branch_taken,
  input  logic [31:0]            branch_target,
`ifdef IF_NULLIFY_EN
  input  logic                   nullify,
`endif
  if_fetch_unit_if.master        imem,
  output logic [31:0]            Inst_out,
  output logic [31:0]            PC_Front_out,
  output logic [31:0]            PC_Back_out,
  output logic                   inst_valid
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_HOLD  = 2'd2;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [31:0] pc_front;
  logic [31:0] pc_back;
  logic [31:0] pc_back_next;
  logic [31:0] inst_buf;
  logic        pend_valid;
  logic [31:0] pend_target;
  logic [31:0] target_aligned;
  logic        advance;
  logic        capture;
  logic        unused_target_bits;

  // Instructions are word aligned; the low target bits carry no information.
  assign target_aligned     = {branch_target[31:2], 2'b00};
  assign unused_target_bits = ^branch_target[1:0];

  assign advance = (state == S_HOLD) && LE;
  assign capture = (state == S_FETCH) && imem.imem_ready;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    state_next = state;
    case (state)
      S_IDLE:  state_next = S_FETCH;
      S_FETCH: if (imem.imem_ready) state_next = S_HOLD;
      S_HOLD:  if (LE) state_next = S_FETCH;
      default: state_next = S_IDLE;
    endcase
  end

  // A branch in the advance cycle itself wins over one remembered during a stall.
  always_comb begin
    pc_back_next = pc_back + 32'd4;
    if (branch_taken) begin
      pc_back_next = target_aligned;
    end else if (pend_valid) begin
      pc_back_next = pend_target;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
    if (Reset) begin
      state       <= S_IDLE;
      pc_front    <= RESET_PC;
      pc_back     <= RESET_PC + 32'd4;
      pend_valid  <= 1'b0;
      pend_target <= '0;
      // NOTE: inst_buf is reset as well, so a reset mid-fetch leaves no captured word behind.
      inst_buf    <= NOP_INST;
    end else begin
      state <= state_next;
      if (capture) begin
        inst_buf <= imem.imem_data;
      end
      if (advance) begin
        pc_front   <= pc_back;
        pc_back    <= pc_back_next;
        pend_valid <= 1'b0;
      end else if (branch_taken) begin
        pend_valid  <= 1'b1;
        pend_target <= target_aligned;
      end
    end
  end

  assign imem.imem_req  = (state == S_FETCH);
  assign imem.imem_addr = pc_front;
  assign inst_valid     = (state == S_HOLD);
  assign PC_Front_out   = pc_front;
  assign PC_Back_out    = pc_back;

  always_comb begin
    Inst_out = NOP_INST;
    if (state == S_HOLD) begin
`ifdef IF_NULLIFY_EN
      // A nullified delay slot still occupies its pipeline slot, just as a NOP.
      Inst_out = nullify ? NOP_INST : inst_buf;
`else
      Inst_out = inst_buf;
`endif
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: queue-based reference model compared every cycle,
// plus directed scenarios with literal expected fetch sequences.
module tb_if_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP_INST = 32'h0800_0240;

  logic        clk = 1'b0;
  logic        Reset;
  logic        LE;
  logic        branch_taken;
  logic [31:0] branch_target;
  logic        ready;
  logic [31:0] Inst_out;
  logic [31:0] PC_Front_out;
  logic [31:0] PC_Back_out;
  logic        inst_valid;
`ifdef IF_NULLIFY_EN
  logic        nullify = 1'b0;
`endif

  int n_checks = 0;
  int n_errors = 0;

  if_fetch_unit_if imem_bus ();

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_bus.imem_data  = inst_of(imem_bus.imem_addr);
  assign imem_bus.imem_ready = ready;

  if_fetch_unit #(.RESET_PC(RESET_PC), .NOP_INST(NOP_INST)) dut (
    .clk           (clk),
    .Reset         (Reset),
    .LE            (LE),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
`ifdef IF_NULLIFY_EN
    .nullify       (nullify),
`endif
    .imem          (imem_bus.master),
    .Inst_out      (Inst_out),
    .PC_Front_out  (PC_Front_out),
    .PC_Back_out   (PC_Back_out),
    .inst_valid    (inst_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded its time budget");
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // pcq[0] is the PC being presented, pcq[1] the next queued PC.
  logic [31:0] pcq[$];
  bit          m_known = 0;
  bit          m_started = 0;
  bit          m_holding = 0;
  bit          m_pend = 0;
  logic [31:0] m_pend_pc;

  function automatic bit nullified();
`ifdef IF_NULLIFY_EN
    return nullify;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk) begin
    bit          adv;
    logic [31:0] nxt;
    if (Reset) begin
      pcq       = {RESET_PC, RESET_PC + 32'd4};
      m_known   = 1;
      m_started = 0;
      m_holding = 0;
      m_pend    = 0;
    end else begin
      adv = m_holding && LE;
      if (adv) begin
        if (branch_taken)  nxt = branch_target & ~32'd3;
        else if (m_pend)   nxt = m_pend_pc;
        else               nxt = pcq[1] + 32'd4;
        void'(pcq.pop_front());
        pcq.push_back(nxt);
        m_pend    = 0;
        m_holding = 0;
      end else if (branch_taken) begin
        m_pend    = 1;
        m_pend_pc = branch_target & ~32'd3;
      end
      if (!m_started)                              m_started = 1;
      else if (!adv && !m_holding && ready)        m_holding = 1;
    end
  end

  always @(negedge clk) begin
    if (m_known) begin
      check("imem_req", {31'd0, imem_bus.imem_req}, {31'd0, m_started && !m_holding});
      if (m_started && !m_holding) check("imem_addr", imem_bus.imem_addr, pcq[0]);
      check("inst_valid", {31'd0, inst_valid}, {31'd0, m_holding});
      check("Inst_out", Inst_out, (m_holding && !nullified()) ? inst_of(pcq[0]) : NOP_INST);
      check("PC_Front_out", PC_Front_out, pcq[0]);
      check("PC_Back_out", PC_Back_out, pcq[1]);
    end
  end

  // Log of completed fetch handshakes, for the literal sequence checks.
  logic [31:0] fetched[$];
  always @(posedge clk) begin
    if (!Reset && imem_bus.imem_req && ready) fetched.push_back(imem_bus.imem_addr);
  end

  function automatic logic [31:0] log_at(input int i);
    if (i < fetched.size()) return fetched[i];
    return 'x;
  endfunction

  task automatic wait_hold(input logic [31:0] pc, input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (inst_valid && PC_Front_out == pc) break;
    end
    check({name, "_pc"}, PC_Front_out, pc);
    check({name, "_valid"}, {31'd0, inst_valid}, 32'd1);
  endtask

  task automatic wait_req(input string name);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (imem_bus.imem_req) break;
    end
    check(name, {31'd0, imem_bus.imem_req}, 32'd1);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int base;
    Reset = 1'b1; LE = 1'b1; branch_taken = 1'b0; branch_target = '0; ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("rst_valid", {31'd0, inst_valid}, 32'd0);
    check("rst_inst", Inst_out, 32'h0800_0240);
    check("rst_front", PC_Front_out, 32'h0000_0000);
    check("rst_back", PC_Back_out, 32'h0000_0004);
    Reset = 1'b0;

    // Zero-wait streaming: fetches 0, 4, 8 in order.
    wait_hold(32'h8, "t1_hold8");
    check("t1_log0", log_at(0), 32'h0);
    check("t1_log1", log_at(1), 32'h4);
    check("t1_log2", log_at(2), 32'h8);

    // Three wait cycles on the fetch of 0xC.
    ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_req", {31'd0, imem_bus.imem_req}, 32'd1);
      check("t2_addr", imem_bus.imem_addr, 32'hC);
      check("t2_valid", {31'd0, inst_valid}, 32'd0);
      check("t2_inst", Inst_out, 32'h0800_0240);
    end
    ready = 1'b1;
    wait_hold(32'hC, "t2_holdC");

    // Stall four cycles holding PC 0x10.
    wait_hold(32'h10, "t3_hold10");
    LE = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t3_inst", Inst_out, 32'h5A5A_0010);
      check("t3_front", PC_Front_out, 32'h10);
      check("t3_req", {31'd0, imem_bus.imem_req}, 32'd0);
    end

    // Branch to 0x100 in the advance cycle: delay slot 0x14, then 0x100, 0x104.
    LE = 1'b1; branch_taken = 1'b1; branch_target = 32'h100;
    base = fetched.size();
    @(negedge clk);
    branch_taken = 1'b0;
    wait_hold(32'h104, "t4_hold104");
    check("t4_slot", log_at(base), 32'h14);
    check("t4_tgt", log_at(base + 1), 32'h100);
    check("t4_next", log_at(base + 2), 32'h104);

    // Two pulses during a stall; the last (0x302 -> 0x300) wins.
    wait_hold(32'h108, "t5_hold108");
    LE = 1'b0; branch_taken = 1'b1; branch_target = 32'h200;
    @(negedge clk);
    branch_target = 32'h302;
    @(negedge clk);
    branch_taken = 1'b0;
    @(negedge clk);
    check("t5_back_pending", PC_Back_out, 32'h10C);
    LE = 1'b1;
    base = fetched.size();
    wait_hold(32'h304, "t5_hold304");
    check("t5_slot", log_at(base), 32'h10C);
    check("t5_tgt", log_at(base + 1), 32'h300);
    check("t5_next", log_at(base + 2), 32'h304);

    // Wrap-around: branch to the last word, queue continues at 0.
    branch_taken = 1'b1; branch_target = 32'hFFFF_FFFF;
    base = fetched.size();
    @(negedge clk);
    branch_taken = 1'b0;
    wait_hold(32'h0, "t7_hold0");
    check("t7_slot", log_at(base), 32'h308);
    check("t7_tgt", log_at(base + 1), 32'hFFFF_FFFC);
    check("t7_wrap", log_at(base + 2), 32'h0);
    check("t7_back", PC_Back_out, 32'h4);

    // Reset while a fetch completes: nothing captured, restart from RESET_PC.
    wait_req("t6_req_seen");
    Reset = 1'b1;
    @(negedge clk);
    check("t6_req", {31'd0, imem_bus.imem_req}, 32'd0);
    check("t6_valid", {31'd0, inst_valid}, 32'd0);
    check("t6_front", PC_Front_out, 32'h0);
    check("t6_inst", Inst_out, 32'h0800_0240);
    Reset = 1'b0;
    base = fetched.size();
    wait_hold(32'h4, "t6_hold4");
    check("t6_log0", log_at(base), 32'h0);
    check("t6_log1", log_at(base + 1), 32'h4);

`ifdef IF_NULLIFY_EN
    wait_hold(32'h8, "tn_hold8");
    LE = 1'b0;
    #1 nullify = 1'b1;
    @(negedge clk);
    check("tn_inst", Inst_out, 32'h0800_0240);
    check("tn_valid", {31'd0, inst_valid}, 32'd1);
    check("tn_front", PC_Front_out, 32'h8);
    nullify = 1'b0;
    LE = 1'b1;
`endif

    repeat (4) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
